// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Holds the arbiter state encoding, the MAX_BURST default, bus widths,
// the request payload struct and the misalignment helper.
package dm_arbiter_pkg;

  localparam int unsigned MAX_BURST_DEFAULT = 4;
  localparam int unsigned BURST_W           = 3;
  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned DATA_W            = 32;

  // Arbiter ownership: IDLE when nobody requested last cycle, else last winner.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // One requester's memory access.
  typedef struct packed {
    logic              we;
    logic              is_byte;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
  } mem_req_t;

  // Word accesses must be 4-byte aligned; byte accesses never fault.
  function automatic logic misaligned(input logic is_byte, input logic [1:0] addr_lo);
    return !is_byte && (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/dm_rr_grant.sv
// Arbitration decision for the two memory requesters.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   valid0, valid1     request present on port 0 / port 1
//   grant0_c, grant1_c combinational grant (at most one set)
// State and burst count are internal registers.
module dm_rr_grant
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  output logic grant0_c,
  output logic grant1_c
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_e         state;
  arb_state_e         state_next;
  logic [BURST_W-1:0] burst;
  logic [BURST_W-1:0] burst_next;
  logic [BURST_W-1:0] burst_inc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      burst <= '0;
    end else begin
      state <= state_next;
      burst <= burst_next;
    end
  end

  // Winner selection and next ownership / burst count.
  always_comb begin
    grant0_c   = 1'b0;
    grant1_c   = 1'b0;
    state_next = state;
    burst_next = burst;
    burst_inc  = (burst >= BURST_MAX) ? BURST_MAX : burst + BURST_W'(1);

    if (reset || (!valid0 && !valid1)) begin
      state_next = ST_IDLE;
      burst_next = '0;
    end else begin
      if (valid0 && valid1) begin
        // Owner keeps the port until its burst is used up; IDLE favours port 0.
        case (state)
          ST_OWN0: grant1_c = (burst == BURST_MAX);
          ST_OWN1: grant1_c = (burst != BURST_MAX);
          default: grant1_c = 1'b0;
        endcase
      end else begin
        grant1_c = valid1;
      end
      grant0_c = !grant1_c;

      if (grant1_c) begin
        state_next = ST_OWN1;
        burst_next = (state == ST_OWN1) ? burst_inc : BURST_W'(1);
      end else begin
        state_next = ST_OWN0;
        burst_next = (state == ST_OWN0) ? burst_inc : BURST_W'(1);
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: port 0 is the pipeline, port 1 debug/DMA.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   p<p>_valid/we/byte/addr/wd       request from port p
//   p<p>_ready                       request accepted this cycle (combinational)
//   p<p>_rvalid/rdata/err            load return one cycle after acceptance
//   mem_we/byte/addr/wd, mem_rd      memory side; mem_rd is a combinational read
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic              p0_we,
  input  logic              p0_byte,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wd,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic              p1_byte,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wd,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  logic              grant0_c;
  logic              grant1_c;
  logic              accept_c;
  logic              mis_c;
  logic              returns_c;
  logic [DATA_W-1:0] load_data_c;
  mem_req_t          req0;
  mem_req_t          req1;
  mem_req_t          win_c;

  logic              rvalid0_q;
  logic              rvalid1_q;
  logic              err0_q;
  logic              err1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  dm_rr_grant #(
    .MAX_BURST (MAX_BURST)
  ) u_grant (
    .clk      (clk),
    .reset    (reset),
    .valid0   (p0_valid),
    .valid1   (p1_valid),
    .grant0_c (grant0_c),
    .grant1_c (grant1_c)
  );

  assign req0 = '{we: p0_we, is_byte: p0_byte, addr: p0_addr, wd: p0_wd};
  assign req1 = '{we: p1_we, is_byte: p1_byte, addr: p1_addr, wd: p1_wd};

  // Winner's request drives the memory; a misaligned word store never writes.
  assign win_c       = grant1_c ? req1 : req0;
  assign accept_c    = grant0_c | grant1_c;
  assign mis_c       = misaligned(win_c.is_byte, win_c.addr[1:0]);
  assign returns_c   = !win_c.we || mis_c;
  assign load_data_c = win_c.is_byte ? DATA_W'(mem_rd[7:0]) : mem_rd;

  assign mem_we   = accept_c && win_c.we && !mis_c;
  assign mem_byte = win_c.is_byte;
  assign mem_addr = win_c.addr;
  // Byte stores present a clean zero-extended byte.
  assign mem_wd   = win_c.is_byte ? DATA_W'(win_c.wd[7:0]) : win_c.wd;

  assign p0_ready = grant0_c;
  assign p1_ready = grant1_c;

  // Load-return registers; rdata only moves when a response is produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= grant0_c && returns_c;
      rvalid1_q <= grant1_c && returns_c;
      err0_q    <= grant0_c && mis_c;
      err1_q    <= grant1_c && mis_c;
      if (grant0_c && returns_c) rdata0_q <= mis_c ? '0 : load_data_c;
      if (grant1_c && returns_c) rdata1_q <= mis_c ? '0 : load_data_c;
    end
  end

  // A response due in the cycle reset rises is dropped, not delivered.
  assign p0_rvalid = rvalid0_q && !reset;
  assign p1_rvalid = rvalid1_q && !reset;
  assign p0_err    = err0_q && !reset;
  assign p1_err    = err1_q && !reset;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_BURST, default 4, the maximum number of consecutive grants to one port while the other port is waiting.
REQ-002 The block SHALL have the port: clk  in  1  rising-edge clock.
REQ-003 The block SHALL have the port: reset  in  1  synchronous, active-high reset.
REQ-004 For each port p in {0,1}, the block SHALL have: p<p>_valid  in  1  request present.
REQ-005 For each port p, the block SHALL have: p<p>_we  in  1  1 = store, 0 = load.
REQ-006 For each port p, the block SHALL have: p<p>_byte  in  1  byte access (1) or word access (0).
REQ-007 For each port p, the block SHALL have: p<p>_addr  in  32  byte address.
REQ-008 For each port p, the block SHALL have: p<p>_wd  in  32  store data; bits [7:0] are used for a byte store.
REQ-009 For each port p, the block SHALL have: p<p>_ready  out  1  request accepted this cycle.
REQ-010 For each port p, the block SHALL have: p<p>_rvalid  out  1  load data valid, or error, for port p.
REQ-011 For each port p, the block SHALL have: p<p>_rdata  out  32  load data, zero-extended for a byte load.
REQ-012 For each port p, the block SHALL have: p<p>_err  out  1  misaligned word access rejected; asserted together with p<p>_rvalid.
REQ-013 The memory side SHALL have: mem_we  out  1, mem_byte  out  1, mem_addr  out  32, mem_wd  out  32, mem_rd  in  32 (combinational read of the addressed word or byte; write on the next clk edge).

Function
REQ-014 Port 0 SHALL be the pipeline port and port 1 the debug/DMA port; at most one request SHALL be accepted per cycle.
REQ-015 A request SHALL be accepted in a cycle where p_valid and p_ready are both 1. p_ready SHALL be combinational from the valids and the arbiter state.
REQ-016 The arbiter SHALL have states IDLE, OWN0 and OWN1, held in a register that records the last winner.
REQ-017 When exactly one port is valid, that port SHALL win, and the state SHALL become OWN of that port.
REQ-018 When both ports are valid, the current owner SHALL win, except as in REQ-019. From IDLE, port 0 SHALL win.
REQ-019 If the owner's burst count equals MAX_BURST and the other port is valid, the other port SHALL win and the burst count SHALL reload to 1.
REQ-020 The burst counter SHALL be 3 bits wide; it SHALL increment on each grant to the same owner and saturate at MAX_BURST.
REQ-021 When neither port is valid, the state SHALL return to IDLE and the burst count SHALL clear to 0.
REQ-022 On acceptance, the mem_* outputs SHALL reflect the winner's request combinationally; mem_we SHALL be 0 in any cycle with no accepted store.
REQ-023 A load SHALL have latency 1: p_rvalid=1 and p_rdata = registered mem_rd in the cycle after acceptance.
REQ-024 A store SHALL produce no rvalid.
REQ-025 A word access with addr[1:0]!=0 SHALL still be accepted, SHALL force mem_we=0, and SHALL produce p_rvalid=1, p_err=1 and p_rdata=0 in the next cycle.
REQ-026 p_rdata SHALL hold its last value when p_rvalid=0.
REQ-027 A requester SHALL keep valid and its request fields stable until ready; the block SHALL NOT check this rule.
REQ-028 Back-to-back acceptance SHALL be supported on every cycle, including alternating ports; a load on one port and a store on the other SHALL occupy separate cycles.

Reset
REQ-029 When reset=1 at a clk edge, the block SHALL set state=IDLE, burst count=0, all rvalid=0, all err=0 and all rdata=0.
REQ-030 Requests presented during reset SHALL NOT be accepted: p_ready=0 and mem_we=0 while reset=1.
REQ-031 A load accepted in the cycle before reset asserts SHALL produce no rvalid.

Structure
REQ-032 The state encoding (IDLE/OWN0/OWN1) and the MAX_BURST default SHALL be placed in the shared CPU package.
REQ-033 The arbitration decision (state, burst count, grant) SHALL be a sub-module named dm_rr_grant; the datapath mux and load-return registers SHALL stay in dm_arbiter.

Verification
REQ-034 The bench SHALL cover: port 0 word load at addr 0x10 with mem_rd=0x12345678 -> p0_ready=1 in cycle 0; cycle 1 p0_rvalid=1, p0_rdata=0x12345678, p1_rvalid=0.
REQ-035 The bench SHALL cover: both ports valid continuously for 10 cycles with MAX_BURST=4, starting from IDLE -> grant order 0,0,0,0,1,1,1,1,0,0.
REQ-036 The bench SHALL cover: port 1 byte store of wd=0xAB to addr 0x23 -> mem_we=1, mem_byte=1, mem_addr=0x23, mem_wd=0x000000AB, with no rvalid afterwards.
REQ-037 The bench SHALL cover: port 0 word load at addr 0x06 -> mem_we=0; next cycle p0_rvalid=1, p0_err=1, p0_rdata=0.
REQ-038 The bench SHALL cover: reset asserted the cycle after a port 1 load is accepted -> p1_rvalid=0, state=IDLE; the first request after reset, from port 1 alone, is granted immediately.
REQ-039 The bench SHALL cover: only port 1 valid for 6 cycles -> granted every cycle, with the burst count saturated at 4 and no stall.
